// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply, 32-cycle restoring divide.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle 33x33 signed multiply.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  dbg_state
);

  // Handshake: start is taken on any edge where busy=0 and flush=0; done pulses for one
  // cycle with result valid, and result holds until the next accepted start writes it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  op;
  logic        neg_a, neg_b;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [4:0]  count;

  logic        signed_a_in, signed_b_in, na_in, nb_in;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, ovf, special, go_fin_in, accept, calc_last;
  logic [31:0] special_res, fin_res, calc_res;

  logic [32:0] mul_sum;
  logic [63:0] acc_step, prod_fix;
  logic [32:0] r_sh, r_diff;
  logic [31:0] quot_step, rem_step, quot_fix, rem_fix;

  // Operand decode on the inputs, used only at the accepting edge.
  always_comb begin
    signed_a_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    na_in       = signed_a_in && a[31];
    nb_in       = signed_b_in && b[31];
    mag_a       = na_in ? (~a + 32'd1) : a;
    mag_b       = nb_in ? (~b + 32'd1) : b;
    div_zero    = funct3[2] && (b == 32'd0);
    ovf         = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                  (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special     = div_zero || ovf;
  end

  always_comb begin
    special_res = 32'hFFFF_FFFF;
    if (div_zero)
      special_res = funct3[1] ? a : 32'hFFFF_FFFF;
    else if (ovf)
      special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [32:0] sa_ext, sb_ext;
  logic [63:0] fast_prod;

  assign sa_ext    = {signed_a_in & a[31], a};
  assign sb_ext    = {signed_b_in & b[31], b};
  assign fast_prod = $signed({{31{sa_ext[32]}}, sa_ext}) * $signed({{31{sb_ext[32]}}, sb_ext});
  assign go_fin_in = special || !funct3[2];
  assign fin_res   = special ? special_res :
                     (funct3 == 3'b000) ? fast_prod[31:0] : fast_prod[63:32];
`else
  assign go_fin_in = special;
  assign fin_res   = special_res;
`endif

  // One shift-add step: add the multiplicand into the high half when the low bit is set, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    acc_step = {mul_sum, acc[31:1]};
    prod_fix = (neg_a ^ neg_b) ? (~acc_step + 64'd1) : acc_step;
  end

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    r_sh   = {rem, quot[31]};
    r_diff = r_sh - {1'b0, opnd};
    if (r_diff[32]) begin
      rem_step  = r_sh[31:0];
      quot_step = {quot[30:0], 1'b0};
    end else begin
      rem_step  = r_diff[31:0];
      quot_step = {quot[30:0], 1'b1};
    end
    quot_fix = (neg_a ^ neg_b) ? (~quot_step + 32'd1) : quot_step;
    rem_fix  = neg_a ? (~rem_step + 32'd1) : rem_step;
  end

  always_comb begin
    calc_res = quot_fix;
    case (op)
      3'b000:                 calc_res = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_fix[63:32];
      3'b100, 3'b101:         calc_res = quot_fix;
      default:                calc_res = rem_fix;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_FIN: begin
        if (flush)      state_nxt = S_IDLE;
        else if (start) state_nxt = go_fin_in ? S_FIN : S_CALC;
        else            state_nxt = S_IDLE;
      end
      S_CALC: begin
        if (flush)                 state_nxt = S_IDLE;
        else if (count == 5'd31)   state_nxt = S_FIN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept    = start && !flush && (state != S_CALC);
  assign calc_last = (state == S_CALC) && !flush && (count == 5'd31);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_CALC);
      done  <= (state_nxt == S_FIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= 3'd0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      opnd   <= 32'd0;
      acc    <= 64'd0;
      quot   <= 32'd0;
      rem    <= 32'd0;
      count  <= 5'd0;
      result <= 32'd0;
    end else if (accept) begin
      op    <= funct3;
      neg_a <= na_in;
      neg_b <= nb_in;
      opnd  <= funct3[2] ? mag_b : mag_a;
      acc   <= {32'd0, mag_b};
      quot  <= mag_a;
      rem   <= 32'd0;
      count <= 5'd0;
      if (go_fin_in) result <= fin_res;
    end else if (state == S_CALC) begin
      count <= count + 5'd1;
      if (op[2]) begin
        quot <= quot_step;
        rem  <= rem_step;
      end else begin
        acc <= acc_step;
      end
      if (calc_last) result <= calc_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table plus hand-written handshake sequences.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int tests;
  int fails;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .funct3    (funct3),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] f, input int lat);
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return lat;
  endfunction

  // Driver: called at a falling edge, start is sampled at the next rising edge.
  task automatic go(input logic [2:0] f, input logic [31:0] va, input logic [31:0] vb);
    start  = 1'b1;
    funct3 = f;
    a      = va;
    b      = vb;
  endtask

  // Waits for done, sampling on falling edges; optionally re-asserts start at cycle inj_cyc.
  task automatic wait_done(input int inj_cyc, input logic [2:0] inj_f,
                           input logic [31:0] inj_a, input logic [31:0] inj_b,
                           output int cyc, output int bcyc, output logic [31:0] res);
    cyc  = 0;
    bcyc = 0;
    res  = 32'hDEAD_BEEF;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy) bcyc++;
      if (done) begin
        res = result;
        return;
      end
      if (cyc == inj_cyc) go(inj_f, inj_a, inj_b);
      if (cyc >= 60) begin
        tests++;
        fails++;
        $display("FAIL timeout: done not seen after %0d cycles, required within 33", cyc);
        return;
      end
    end
  endtask

  initial begin
    int cyc, bcyc, lat, seen;
    logic [31:0] res;

    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'd0;
    a      = 32'd0;
    b      = 32'd0;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, 1};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{3'b000, 32'h1234_5678, 32'h10,        32'h2345_6780, 33};
    vecs[13] = '{3'b011, 32'h8000_0000, 32'd4,         32'h0000_0002, 33};
    vecs[14] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[15] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[16] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[17] = '{3'b100, 32'h8000_0000, 32'd3,         32'hD555_5556, 33};
    vecs[18] = '{3'b110, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 33};
    vecs[19] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", result,        32'd0);
    check("reset_state",  {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      lat = exp_lat(vecs[i].f, vecs[i].lat);
      go(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_done(0, 3'd0, 32'd0, 32'd0, cyc, bcyc, res);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(lat));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcyc), 32'(lat - 1));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // start while busy is ignored
    go(3'b101, 32'd1000, 32'd10);
    wait_done(10, 3'b000, 32'd6, 32'd7, cyc, bcyc, res);
    check("busy_start_result",  res,        32'd100);
    check("busy_start_latency", 32'(cyc),   32'd33);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("busy_start_no_second_op", 32'(seen), 32'd0);

    // Back-to-back: second start in the FIN cycle
    go(3'b101, 32'd100, 32'd7);
    wait_done(0, 3'd0, 32'd0, 32'd0, cyc, bcyc, res);
    check("b2b_first_result", res, 32'd14);
    go(3'b111, 32'd100, 32'd7);
    wait_done(0, 3'd0, 32'd0, 32'd0, cyc, bcyc, res);
    check("b2b_second_result",  res,      32'd2);
    check("b2b_second_latency", 32'(cyc), 32'd33);
    @(negedge clk);

    // Flush at count=15: count k is live during cycle k+1 after the accepting edge
    go(3'b100, 32'hFFFF_FFF9, 32'd2);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 16) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy",  {31'd0, busy},      32'd0);
    check("flush_done",  {31'd0, done},      32'd0);
    check("flush_state", {30'd0, dbg_state}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_result_kept", result, 32'd2);

    // flush beats a simultaneous start (special op would otherwise finish in one cycle)
    go(3'b101, 32'h0000_1234, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_done",   {31'd0, done}, 32'd0);
    check("flush_start_result", result,        32'd2);

    // Asynchronous reset mid-CALC
    go(3'b101, 32'd100, 32'd7);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy",   {31'd0, busy}, 32'd0);
    check("async_reset_done",   {31'd0, done}, 32'd0);
    check("async_reset_result", result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_state", {30'd0, dbg_state}, 32'd0);
    check("post_reset_busy",  {31'd0, busy},      32'd0);
    go(3'b111, 32'd100, 32'd7);
    wait_done(0, 3'd0, 32'd0, 32'd0, cyc, bcyc, res);
    check("post_reset_result",  res,      32'd2);
    check("post_reset_latency", 32'(cyc), 32'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage. It takes the same two 32-bit operands the ALU receives and a funct3 selector, and runs a multi-cycle shift-add or shift-subtract sequence. It returns the 32-bit result through a start/busy/done handshake to the writeback mux. The pipeline controller stalls on `busy` and steers `result` instead of `alu_result` when `done` pulses.

## Interface
- No parameters; data width fixed at 32.
- `clk`  input  1  single clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; accepted only when `busy`=0.
- `flush`  input  1  synchronous abort of an in-flight operation.
- `funct3`  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  input  32  rs1 operand (multiplicand / dividend).
- `b`  input  32  rs2 operand (multiplier / divisor).
- `busy`  output  1  operation in progress.
- `done`  output  1  one-cycle pulse; `result` valid.
- `result`  output  32  final value; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIN.
- IDLE: when `start`=1, latch `a`, `b` and `funct3`, then go to CALC with count=0. Signed ops first latch the operand magnitudes plus sign flags.
  - Signed operands: MULH, DIV and REM treat both operands as signed; MULHSU treats only `a` as signed.
- Special cases skip CALC and go straight to FIN:
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = `a`.
  - Signed overflow (DIV/REM with `a`=0x80000000, `b`=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- CALC: one iteration per cycle over 32 cycles (count 0..31).
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring shift-subtract, 32-bit quotient and 33-bit partial remainder.
  - After count=31, go to FIN.
- Sign fix on the transition into FIN:
  - Product: negated (64-bit two's complement) if the sign flags differ.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the sign of the dividend.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- `result` register is written on entry to FIN.
- FIN: `done`=1 and `busy`=0. Next state is CALC (or FIN for a special case) if `start`=1 in this cycle, else IDLE.
- `start` while `busy`=1 is ignored; there is no queueing.
- `flush`=1 in CALC: return to IDLE next edge, no `done`, `result` unchanged.
  - `flush` beats a simultaneous `start` in any state.
  - `flush` in FIN suppresses nothing; `done` is already visible that cycle.
- Reset (any time, including mid-CALC): state IDLE, `busy`=0, `done`=0, `result`=0, count=0, internal accumulators=0.

## Timing
- Start sampled at edge E0.
- Normal op:
  - `busy`=1 from E0 to E32.
  - `done`=1 for one cycle, E32 to E33.
  - Latency 33 cycles start-to-done.
- Special case: `done`=1 from E0 to E1 (latency 1), with `busy` never asserted.
- Back-to-back: `start` asserted during the FIN cycle is accepted at that edge, giving throughput of one op per 33 cycles.
- Operand inputs are don't-care after the accepting edge.
- `busy`, `done` and `result` are registered outputs, with no combinational path from the inputs.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU use a single 33x33 signed multiply on the latched, sign-extended operands. They go IDLE→FIN directly, with latency 1, same as the special cases. Division is unchanged.
- Undefined: all four multiply ops use the 32-cycle iterative path described above (latency 33). No hardware multiplier is inferred.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → `done` 33 cycles after start, `result`=0xFFFFFFEB. With `MULDIV_FAST_MUL_EN`: done after 1 cycle.
- MULHU a=b=0xFFFFFFFF → `result`=0xFFFFFFFE. MULH on the same operands → 0x00000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU on the same operands → 2.
- DIVU/REMU by b=0 with a=0x1234 → results 0xFFFFFFFF and 0x1234, `done` one cycle after start, `busy` never high. DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Assert `start` at cycle 10 of an operation → ignored, first result unaffected. Assert `start` in the FIN cycle → second op accepted, its `done` arrives 33 cycles later.
- Assert `flush` at count=15 → no `done`, `busy`=0 next cycle, `result` keeps its prior value. Assert `rst_n`=0 mid-CALC → all outputs 0 immediately (asynchronous), IDLE after release.
